// File: rtl/zork_pkg.sv
// Shared definitions for the keypad front end of the game: direction key
// codes, the 4x4 keypad map and the scanner state encoding.
package zork_pkg;

    // Direction keys as consumed by game_control
    localparam logic [3:0] KEY_UP    = 4'h2;
    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;
    localparam logic [3:0] KEY_DOWN  = 4'h8;

    // Scanner states
    typedef enum logic [2:0] {
        SCAN     = 3'd0,  // walking the columns, sampling rows once per dwell
        DEBOUNCE = 3'd1,  // candidate key must stay low for the full window
        PRESS    = 3'd2,  // single cycle: code registered, valid pulsed
        HELD     = 3'd3,  // key accepted, waiting for it to go high
        RELEASE  = 3'd4   // candidate row must stay high for the full window
    } scan_state_t;

    // Keypad legend (row r, column c):
    //   r0: 1 2 3 A
    //   r1: 4 5 6 B
    //   r2: 7 8 9 C
    //   r3: E 0 F D   (E is '*', F is '#')
    function automatic logic [3:0] key_map(input logic [1:0] row,
                                           input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = KEY_UP;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = KEY_LEFT;
            4'b01_01: code = 4'h5;
            4'b01_10: code = KEY_RIGHT;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = KEY_DOWN;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for slow, level-type inputs that arrive
// asynchronously to clk. Each bit is synchronised independently; the
// reset value lets idle-high inputs (pulled-up rows) start at their idle level.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Capture the raw input, then let any metastability settle for a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample on the
            // same edge; blocking ones would collapse the chain to one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Drives one column low at a time, samples the synchronised rows at the end
// of each column dwell, debounces the first key found and reports its hex
// code with a one-cycle valid pulse. While a key is pending or held the
// column stays frozen, so other keys are ignored until a full release.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid_o every
// REPEAT_CYC cycles while the key is held.
module keypad_scanner
    import zork_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,    // cycles per column, >= 4
    parameter int DEBOUNCE_CYC = 1000000,  // stable cycles to accept, >= 2
    parameter int REPEAT_CYC   = 12500000  // auto-repeat period, >= 2
) (
    input  logic       clk_50MHz_i,
    input  logic       rst_async_ha_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYC);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);

    logic [3:0]         rs;          // synchronised rows, active-low
    scan_state_t        state;
    logic [1:0]         col_idx;     // column currently driven low
    logic [1:0]         cand_row;    // row of the key being debounced/held
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DEB_W-1:0]   deb_cnt;

    logic       any_low;
    logic [1:0] first_low;
    logic       cand_low;
    logic       sample;
    logic       deb_done;
    logic       advance;

    // Rows are pulled up, so they idle (and reset) high
    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk (clk_50MHz_i),
        .rst (rst_async_ha_i),
        .d   (row_i),
        .q   (rs)
    );

    assign any_low  = ~&rs;
    assign cand_low = ~rs[cand_row];
    assign sample   = (dwell_cnt == DWELL_LAST);
    assign deb_done = (deb_cnt == DEB_LAST);

    // Lowest-index low row wins when several rows in the column are pressed
    always_comb begin
        // NOTE: assigning a default before any condition keeps this block
        // purely combinational; a path that skips the assignment infers a latch.
        first_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) first_low = 2'(i);
        end
    end

    // Decide when the scan moves on to the next column
    always_comb begin
        advance = 1'b0;
        case (state)
            SCAN:     advance = sample && !any_low;
            DEBOUNCE: advance = !cand_low;
            RELEASE:  advance = !cand_low && deb_done;
            default:  advance = 1'b0;
        endcase
    end

    // Column drive: registered so the pins never glitch, rotated one step
    // per advance (1110 -> 1101 -> 1011 -> 0111 -> 1110)
    always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
        if (rst_async_ha_i) begin
            col_idx <= 2'd0;
            col_o   <= 4'b1110;
        end else if (advance) begin
            col_idx <= col_idx + 2'd1;
            col_o   <= {col_o[2:0], col_o[3]};
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int                REP_W    = $clog2(REPEAT_CYC);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYC - 1);
    // Pulse is registered, so it is requested one count before the period ends
    localparam logic [REP_W-1:0]  REP_FIRE = REP_W'(REPEAT_CYC - 2);

    logic [REP_W-1:0] rep_cnt;
`else
    // Without auto-repeat the period has no effect on the hardware
    logic unused_repeat;
    assign unused_repeat = (REPEAT_CYC > 1);
`endif

    // Scan, debounce and report state machine with its counters and outputs.
    // The column stays frozen outside SCAN, so col_idx is the candidate column.
    always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
        if (rst_async_ha_i) begin
            state       <= SCAN;
            dwell_cnt   <= '0;
            deb_cnt     <= '0;
            cand_row    <= 2'd0;
            key_code_o  <= 4'h0;
            key_valid_o <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            key_valid_o <= 1'b0;
            case (state)
                SCAN: begin
                    if (sample) begin
                        dwell_cnt <= '0;
                        if (any_low) begin
                            cand_row <= first_low;
                            deb_cnt  <= '0;
                            state    <= DEBOUNCE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (!cand_low) begin
                        // Bounce: give up on this key and keep scanning
                        deb_cnt <= '0;
                        state   <= SCAN;
                    end else if (deb_done) begin
                        deb_cnt     <= '0;
                        key_code_o  <= key_map(cand_row, col_idx);
                        key_valid_o <= 1'b1;
                        state       <= PRESS;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                PRESS: begin
                    state <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt <= '0;
`endif
                end

                HELD: begin
                    if (!cand_low) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else begin
                        // Counter sits at REP_LAST during each repeat pulse
                        // and clears right after it
                        if (rep_cnt == REP_LAST) begin
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                        if (rep_cnt == REP_FIRE) begin
                            key_valid_o <= 1'b1;
                        end
                    end
`endif
                end

                RELEASE: begin
                    if (cand_low) begin
                        // Release glitch: still the same press, no new pulse
                        deb_cnt <= '0;
                        state   <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt <= '0;
`endif
                    end else if (deb_done) begin
                        deb_cnt <= '0;
                        state   <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule
